// File: rtl/hazard_sched_pkg.sv
// Shared types for the hazard scheduler: MULT/DIV sequencer state encodings,
// conditional-kill select codes and the load-use compare.
package hazard_sched_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  localparam logic [1:0] CLR_KILL = 2'b01;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
  endfunction

endpackage

// File: rtl/hazard_sched_md_seq.sv
// MULT/DIV sequencer: accepts an operation, counts out its latency with a
// down-counter and pulses hilo_we once when the HI/LO result is due.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | unit free; start latches operands (go) and loads counter
// MD_RUN  | operation in flight; counter runs down to terminal count
// MD_DONE | result cycle; hilo_we asserted for exactly this cycle
module md_seq
  import hazard_sched_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  output logic go,
  output logic busy,
  output logic hilo_we
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 2);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go      = 1'b0;
    busy    = 1'b0;
    hilo_we = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          go      = 1'b1;
          cnt_d   = div ? DIV_LOAD : MULT_LOAD;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        busy = 1'b1;
        // Accept and DONE cycles each count toward the latency, so RUN
        // leaves on the count of 1 to land hilo_we LAT-1 cycles after go.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MD_DONE: begin
        busy    = 1'b1;
        hilo_we = 1'b1;
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline stall/flush scheduler: load-use and HI/LO-pending stalls, branch and
// conditional-kill flushes, MULT/DIV sequencing. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rt,
  input  logic        ex_mem_read,
  input  logic        id_br_taken,
  input  logic [1:0]  clr_sel,
  input  logic        ex_zero,
  input  logic        id_md_start,
  input  logic        id_md_div,
  input  logic        id_hilo_rd,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_clr,
  output logic        id_ex_clr,
  output logic        md_go,
  output logic        md_busy,
  output logic        hilo_we,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic load_use;
  logic md_hold;
  logic stall;
  logic cond_kill;

  assign load_use  = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt);
  assign md_hold   = md_busy && (id_md_start || id_hilo_rd);
  assign stall     = load_use || md_hold;
  assign cond_kill = (clr_sel == CLR_KILL) && !ex_zero;

  assign pc_stall    = stall;
  assign if_id_stall = stall;
  assign id_ex_clr   = stall || cond_kill;
  // A stalled branch stays in ID and re-resolves, so the flush waits for it.
  assign if_id_clr   = id_br_taken && !stall;

  md_seq #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (id_md_start && !load_use),
    .div     (id_md_div),
    .go      (md_go),
    .busy    (md_busy),
    .hilo_we (hilo_we)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if ((if_id_clr || cond_kill) && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed self-checking bench for hazard_sched (MULT_LAT=4, DIV_LAT=32).
module tb_hazard_sched;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, id_br_taken, ex_zero;
  logic [1:0]  clr_sel;
  logic        id_md_start, id_md_div, id_hilo_rd;
  logic        pc_stall, if_id_stall, if_id_clr, id_ex_clr;
  logic        md_go, md_busy, hilo_we;
  logic [31:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_sched #(.MULT_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_rt       (ex_rt),
    .ex_mem_read (ex_mem_read),
    .id_br_taken (id_br_taken),
    .clr_sel     (clr_sel),
    .ex_zero     (ex_zero),
    .id_md_start (id_md_start),
    .id_md_div   (id_md_div),
    .id_hilo_rd  (id_hilo_rd),
    .pc_stall    (pc_stall),
    .if_id_stall (if_id_stall),
    .if_id_clr   (if_id_clr),
    .id_ex_clr   (id_ex_clr),
    .md_go       (md_go),
    .md_busy     (md_busy),
    .hilo_we     (hilo_we),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; id_br_taken = 1'b0; ex_zero = 1'b0;
    clr_sel = 2'b00; id_md_start = 1'b0; id_md_div = 1'b0; id_hilo_rd = 1'b0;
  endtask

  // advance one clock edge and leave the bench 1 unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hilo_seen;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
    check("rst_if_id_clr", {31'd0, if_id_clr}, 32'd0);
    check("rst_id_ex_clr", {31'd0, id_ex_clr}, 32'd0);
    check("rst_md_go", {31'd0, md_go}, 32'd0);
    check("rst_md_busy", {31'd0, md_busy}, 32'd0);
    check("rst_hilo_we", {31'd0, hilo_we}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);

    // load-use via rs (stall #1)
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    #1;
    check("lu_rs_pc_stall", {31'd0, pc_stall}, 32'd1);
    check("lu_rs_if_id_stall", {31'd0, if_id_stall}, 32'd1);
    check("lu_rs_id_ex_clr", {31'd0, id_ex_clr}, 32'd1);
    check("lu_rs_if_id_clr", {31'd0, if_id_clr}, 32'd0);
    tick();
    // load to r0 never stalls
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    check("lu_r0_pc_stall", {31'd0, pc_stall}, 32'd0);
    check("lu_r0_id_ex_clr", {31'd0, id_ex_clr}, 32'd0);
    tick();
    // load-use via rt (stall #2)
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
    #1;
    check("lu_rt_pc_stall", {31'd0, pc_stall}, 32'd1);
    tick();
    // no register match
    id_rt = 5'd4;
    #1;
    check("lu_miss_pc_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    // non-load with matching regs
    ex_mem_read = 1'b0; id_rt = 5'd7;
    #1;
    check("nonload_pc_stall", {31'd0, pc_stall}, 32'd0);
    tick();

    // taken branch, no hazard (flush #1)
    idle();
    id_br_taken = 1'b1;
    #1;
    check("br_if_id_clr", {31'd0, if_id_clr}, 32'd1);
    check("br_pc_stall", {31'd0, pc_stall}, 32'd0);
    check("br_id_ex_clr", {31'd0, id_ex_clr}, 32'd0);
    tick();
    // taken branch under load-use: stall wins (stall #3)
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    check("br_lu_if_id_clr", {31'd0, if_id_clr}, 32'd0);
    check("br_lu_pc_stall", {31'd0, pc_stall}, 32'd1);
    tick();

    // conditional kill (flush #2)
    idle();
    clr_sel = 2'b01; ex_zero = 1'b0;
    #1;
    check("kill_id_ex_clr", {31'd0, id_ex_clr}, 32'd1);
    check("kill_pc_stall", {31'd0, pc_stall}, 32'd0);
    check("kill_if_id_clr", {31'd0, if_id_clr}, 32'd0);
    tick();
    ex_zero = 1'b1;
    #1;
    check("kill_zero_id_ex_clr", {31'd0, id_ex_clr}, 32'd0);
    tick();
    clr_sel = 2'b00; ex_zero = 1'b0;
    #1;
    check("kill_sel00_id_ex_clr", {31'd0, id_ex_clr}, 32'd0);
    tick();
    clr_sel = 2'b10;
    #1;
    check("kill_sel10_id_ex_clr", {31'd0, id_ex_clr}, 32'd0);
    tick();

    // perf counters: 3 stall cycles, 2 flush events so far
    idle();
    #1;
    check("perf_stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
    check("perf_flush_cnt", flush_cnt, PERF ? 32'd2 : 32'd0);

    // MULT start blocked by load-use
    id_md_start = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    #1;
    check("md_lu_md_go", {31'd0, md_go}, 32'd0);
    tick();
    #1;
    check("md_lu_md_busy", {31'd0, md_busy}, 32'd0);

    // MULT accepted at cycle 0, MFHI waiting in ID cycles 1..4
    idle();
    id_md_start = 1'b1;
    #1;
    check("mult_c0_md_go", {31'd0, md_go}, 32'd1);
    check("mult_c0_pc_stall", {31'd0, pc_stall}, 32'd0);
    check("mult_c0_hilo_we", {31'd0, hilo_we}, 32'd0);
    tick();
    id_md_start = 1'b0; id_hilo_rd = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("mult_c%0d_md_go", c), {31'd0, md_go}, 32'd0);
      check($sformatf("mult_c%0d_hilo_we", c), {31'd0, hilo_we}, (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("mult_c%0d_md_busy", c), {31'd0, md_busy}, (c <= 3) ? 32'd1 : 32'd0);
      check($sformatf("mult_c%0d_pc_stall", c), {31'd0, pc_stall}, (c <= 3) ? 32'd1 : 32'd0);
      tick();
    end

    // DIV at cycle 0, MULT waiting in ID behind it
    idle();
    id_md_start = 1'b1; id_md_div = 1'b1;
    #1;
    check("div_c0_md_go", {31'd0, md_go}, 32'd1);
    tick();
    id_md_div = 1'b0;
    hilo_seen = 0;
    for (int c = 1; c <= 31; c++) begin
      #1;
      if (hilo_we) hilo_seen = c;
      check($sformatf("div_c%0d_pc_stall", c), {31'd0, pc_stall}, 32'd1);
      check($sformatf("div_c%0d_md_go", c), {31'd0, md_go}, 32'd0);
      tick();
    end
    check("div_hilo_cycle", hilo_seen, 32'd31);
    #1;
    check("b2b_c32_md_go", {31'd0, md_go}, 32'd1);
    check("b2b_c32_pc_stall", {31'd0, pc_stall}, 32'd0);
    check("b2b_c32_md_busy", {31'd0, md_busy}, 32'd0);
    tick();
    idle();
    for (int c = 33; c <= 35; c++) begin
      #1;
      check($sformatf("b2b_c%0d_hilo_we", c), {31'd0, hilo_we}, (c == 35) ? 32'd1 : 32'd0);
      tick();
    end

    // DIV aborted by reset at cycle 10
    id_md_start = 1'b1; id_md_div = 1'b1;
    #1;
    check("abort_c0_md_go", {31'd0, md_go}, 32'd1);
    tick();
    idle();
    for (int c = 1; c < 10; c++) tick();
    #1;
    check("abort_c10_md_busy", {31'd0, md_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_c11_md_busy", {31'd0, md_busy}, 32'd0);
    check("abort_c11_stall_cnt", stall_cnt, 32'd0);
    check("abort_c11_flush_cnt", flush_cnt, 32'd0);
    hilo_seen = 0;
    for (int c = 11; c < 50; c++) begin
      if (hilo_we || md_busy) hilo_seen++;
      tick();
    end
    check("abort_no_hilo_we", hilo_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
